// File: rtl/sdram_init.sv
// SDRAM power-up sequencer: waits for clock lock, then issues the standard start-up
// sequence (power-up NOPs, precharge-all, auto-refreshes, load mode) and raises done.
module sdram_init #(
    parameter int unsigned T_POWERUP   = 5000,
    parameter int unsigned T_RP        = 2,
    parameter int unsigned T_RFC       = 4,
    parameter int unsigned T_MRD       = 2,
    parameter int unsigned NUM_REFRESH = 2,
    parameter logic [12:0] MODE        = 13'h0022
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ok,
    output logic        cke,
    output logic [3:0]  cmd,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic        done
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Wait states run for T-1 cycles; a count of zero skips the state entirely.
    localparam int RP_WAIT  = int'(T_RP) - 1;
    localparam int RFC_WAIT = int'(T_RFC) - 1;
    localparam int MRD_WAIT = int'(T_MRD) - 1;

    localparam logic [15:0] PU_LAST  = 16'(int'(T_POWERUP) - 1);
    localparam logic [15:0] RP_LAST  = 16'(RP_WAIT - 1);
    localparam logic [15:0] RFC_LAST = 16'(RFC_WAIT - 1);
    localparam logic [15:0] MRD_LAST = 16'(MRD_WAIT - 1);
    localparam logic [4:0]  NUM_REF  = 5'(NUM_REFRESH);

    typedef enum logic [3:0] {
        WAIT_CLK,
        POWERUP,
        PRE,
        WAIT_RP,
        REF,
        WAIT_RFC,
        LMR,
        WAIT_MRD,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [3:0]  ref_cnt_reg, ref_cnt_next;
    logic [4:0]  ref_cnt_inc;

    logic        cke_reg, cke_next;
    logic [3:0]  cmd_reg, cmd_next;
    logic [1:0]  ba_reg, ba_next;
    logic [12:0] addr_reg, addr_next;
    logic        done_reg, done_next;

    assign ref_cnt_inc = {1'b0, ref_cnt_reg} + 5'd1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_CLK: if (clk_ok) state_next = POWERUP;
            POWERUP:  if (wait_cnt_reg == PU_LAST) state_next = PRE;
            PRE:      state_next = (RP_WAIT == 0) ? REF : WAIT_RP;
            WAIT_RP:  if (wait_cnt_reg == RP_LAST) state_next = REF;
            REF: begin
                if (RFC_WAIT != 0)
                    state_next = WAIT_RFC;
                else
                    state_next = (ref_cnt_inc < NUM_REF) ? REF : LMR;
            end
            WAIT_RFC: begin
                if (wait_cnt_reg == RFC_LAST)
                    state_next = ({1'b0, ref_cnt_reg} < NUM_REF) ? REF : LMR;
            end
            LMR:      state_next = (MRD_WAIT == 0) ? DONE : WAIT_MRD;
            WAIT_MRD: if (wait_cnt_reg == MRD_LAST) state_next = DONE;
            DONE:     state_next = DONE;
            default:  state_next = WAIT_CLK;
        endcase
        // Losing lock anywhere forces a full restart.
        if (!clk_ok) state_next = WAIT_CLK;
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg + 16'd1;
        if (state_next != state_reg || state_reg == WAIT_CLK || state_reg == DONE)
            wait_cnt_next = 16'd0;

        ref_cnt_next = ref_cnt_reg;
        if (state_next == WAIT_CLK || state_reg == WAIT_CLK || state_reg == PRE)
            ref_cnt_next = 4'd0;
        else if (state_reg == REF)
            ref_cnt_next = ref_cnt_inc[3:0];
    end

    // Pin values follow the current state one edge later, except that loss of lock
    // idles the pins on the very edge it is seen.
    always_comb begin
        cke_next  = 1'b1;
        cmd_next  = CMD_NOP;
        ba_next   = 2'd0;
        addr_next = 13'd0;
        done_next = 1'b0;
        case (state_reg)
            WAIT_CLK: cke_next = 1'b0;
            PRE: begin
                cmd_next  = CMD_PRE;
                addr_next = 13'h0400;
            end
            REF:  cmd_next = CMD_REF;
            LMR: begin
                cmd_next  = CMD_LMR;
                addr_next = MODE;
            end
            DONE: done_next = 1'b1;
            default: ;
        endcase
        if (!clk_ok) begin
            cke_next  = 1'b0;
            cmd_next  = CMD_NOP;
            addr_next = 13'd0;
            done_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= WAIT_CLK;
            wait_cnt_reg <= 16'd0;
            ref_cnt_reg  <= 4'd0;
            cke_reg      <= 1'b0;
            cmd_reg      <= CMD_NOP;
            ba_reg       <= 2'd0;
            addr_reg     <= 13'd0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            ref_cnt_reg  <= ref_cnt_next;
            cke_reg      <= cke_next;
            cmd_reg      <= cmd_next;
            ba_reg       <= ba_next;
            addr_reg     <= addr_next;
            done_reg     <= done_next;
        end
    end

    assign cke  = cke_reg;
    assign cmd  = cmd_reg;
    assign ba   = ba_reg;
    assign addr = addr_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_sdram_init.sv
// Directed bench for sdram_init: timeline tables for the nominal and lock-loss
// sequences, plus hand-written checks for reset, long DONE hold and minimum timings.
module tb_sdram_init;

    localparam int TP = 8, TRP = 2, TRFC = 4, TMRD = 2, NR = 2;
    localparam logic [3:0] NOP = 4'b0111, PREC = 4'b0010, AREF = 4'b0001, LMRC = 4'b0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_m, clk_ok_m, cke_m, done_m;
    logic [3:0]  cmd_m;
    logic [1:0]  ba_m;
    logic [12:0] addr_m;

    logic        reset_f, clk_ok_f, cke_f, done_f;
    logic [3:0]  cmd_f;
    logic [1:0]  ba_f;
    logic [12:0] addr_f;

    sdram_init #(.T_POWERUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
                 .NUM_REFRESH(NR), .MODE(13'h0032)) u_main (
        .clk(clk), .reset(reset_m), .clk_ok(clk_ok_m), .cke(cke_m),
        .cmd(cmd_m), .ba(ba_m), .addr(addr_m), .done(done_m));

    sdram_init #(.T_POWERUP(3), .T_RP(1), .T_RFC(1), .T_MRD(1),
                 .NUM_REFRESH(8), .MODE(13'h0022)) u_fast (
        .clk(clk), .reset(reset_f), .clk_ok(clk_ok_f), .cke(cke_f),
        .cmd(cmd_f), .ba(ba_f), .addr(addr_f), .done(done_f));

    typedef struct {
        logic        clk_ok;
        logic        cke;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic        done;
    } vec_t;

    vec_t tbl [0:63];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected pins for edges first..last when lock is first sampled high at edge k.
    task automatic fill_from(input int k, input int first, input int last);
        int p, l;
        p = k + 1 + TP;
        l = p + TRP + NR * TRFC;
        for (int e = first; e <= last; e++) begin
            tbl[e].clk_ok = (e >= k);
            tbl[e].cke    = (e >= k + 1);
            tbl[e].cmd    = NOP;
            tbl[e].addr   = 13'd0;
            tbl[e].done   = (e >= l + TMRD);
            if (e == p) begin tbl[e].cmd = PREC; tbl[e].addr = 13'h0400; end
            for (int i = 0; i < NR; i++)
                if (e == p + TRP + i * TRFC) tbl[e].cmd = AREF;
            if (e == l) begin tbl[e].cmd = LMRC; tbl[e].addr = 13'h0032; end
        end
    endtask

    task automatic run_table(input string tag, input int first, input int last);
        for (int e = first; e <= last; e++) begin
            clk_ok_m = tbl[e].clk_ok;
            @(posedge clk); #1;
            chk($sformatf("%s_cke_e%0d", tag, e), 32'(cke_m), 32'(tbl[e].cke));
            chk($sformatf("%s_cmd_e%0d", tag, e), 32'(cmd_m), 32'(tbl[e].cmd));
            chk($sformatf("%s_addr_e%0d", tag, e), 32'(addr_m), 32'(tbl[e].addr));
            chk($sformatf("%s_ba_e%0d", tag, e), 32'(ba_m), 32'd0);
            chk($sformatf("%s_done_e%0d", tag, e), 32'(done_m), 32'(tbl[e].done));
        end
    endtask

    task automatic reset_main(input string tag);
        reset_m = 1'b1;
        clk_ok_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_cke"}, 32'(cke_m), 32'd0);
        chk({tag, "_rst_cmd"}, 32'(cmd_m), 32'(NOP));
        chk({tag, "_rst_addr"}, 32'(addr_m), 32'd0);
        chk({tag, "_rst_done"}, 32'(done_m), 32'd0);
        reset_m = 1'b0;
    endtask

    initial begin
        int bad, refs;
        reset_m = 1'b1; clk_ok_m = 1'b0;
        reset_f = 1'b1; clk_ok_f = 1'b0;

        // Nominal sequence: lock at edge 3, PRE 12, REF 14/18, LMR 22, done 24.
        reset_main("nom");
        fill_from(3, 1, 26);
        run_table("nom", 1, 26);
        $display("nominal sequence checked through edge 26");

        // No lock for 100 cycles: pins stay idle.
        reset_main("nolock");
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            clk_ok_m = 1'b0;
            @(posedge clk); #1;
            if (cke_m !== 1'b0 || cmd_m !== NOP || done_m !== 1'b0) bad++;
        end
        chk("nolock_idle_cycles_bad", 32'(bad), 32'd0);
        $display("100 cycles without lock checked");

        // Lock drops at edge 16 between the REFs, returns at edge 17.
        reset_main("drop");
        fill_from(3, 1, 15);
        fill_from(17, 16, 42);
        tbl[16].clk_ok = 1'b0;
        run_table("drop", 1, 25);
        refs = 0;
        for (int e = 26; e <= 42; e++) begin
            clk_ok_m = tbl[e].clk_ok;
            @(posedge clk); #1;
            if (cmd_m === AREF) refs++;
            chk($sformatf("drop_cmd_e%0d", e), 32'(cmd_m), 32'(tbl[e].cmd));
            chk($sformatf("drop_done_e%0d", e), 32'(done_m), 32'(tbl[e].done));
        end
        chk("drop_refs_after_new_pre", 32'(refs), 32'd2);
        $display("lock-drop restart checked");

        // Reset asserted during WAIT_MRD (after LMR at edge 22).
        reset_main("mrd");
        fill_from(3, 1, 22);
        run_table("mrd", 1, 22);
        reset_m = 1'b1;
        @(posedge clk); #1;
        chk("mrd_reset_cke", 32'(cke_m), 32'd0);
        chk("mrd_reset_cmd", 32'(cmd_m), 32'(NOP));
        chk("mrd_reset_addr", 32'(addr_m), 32'd0);
        chk("mrd_reset_done", 32'(done_m), 32'd0);
        reset_m = 1'b0;
        fill_from(1, 1, 22);
        run_table("rst_restart", 1, 22);
        $display("reset in WAIT_MRD and restart checked");

        // Hold DONE for 1000 cycles, then lose lock.
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            clk_ok_m = 1'b1;
            @(posedge clk); #1;
            if (done_m !== 1'b1 || cmd_m !== NOP || cke_m !== 1'b1 || addr_m !== 13'd0) bad++;
        end
        chk("done_hold_bad_cycles", 32'(bad), 32'd0);
        clk_ok_m = 1'b0;
        @(posedge clk); #1;
        chk("done_drop_done", 32'(done_m), 32'd0);
        chk("done_drop_cke", 32'(cke_m), 32'd0);
        chk("done_drop_cmd", 32'(cmd_m), 32'(NOP));
        $display("DONE hold and lock loss checked");

        // Minimum timings: PRE, 8 REFs, LMR on consecutive edges 5..14, done at 15.
        clk_ok_f = 1'b0;
        @(posedge clk); #1;
        reset_f = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            logic [3:0]  exp_cmd;
            logic [12:0] exp_addr;
            clk_ok_f = 1'b1;
            @(posedge clk); #1;
            exp_cmd = NOP;
            exp_addr = 13'd0;
            if (e == 5) begin exp_cmd = PREC; exp_addr = 13'h0400; end
            if (e >= 6 && e <= 13) exp_cmd = AREF;
            if (e == 14) begin exp_cmd = LMRC; exp_addr = 13'h0022; end
            chk($sformatf("fast_cmd_e%0d", e), 32'(cmd_f), 32'(exp_cmd));
            chk($sformatf("fast_addr_e%0d", e), 32'(addr_f), 32'(exp_addr));
            chk($sformatf("fast_done_e%0d", e), 32'(done_f), 32'(e >= 15));
            chk($sformatf("fast_cke_e%0d", e), 32'(cke_f), 32'(e >= 2));
        end
        $display("minimum-timing sequence checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
